// File: rtl/inst_issue_unit_pkg.sv
// Shared widths, opcodes, idle encodings and FU class decode for the issue stage.
package inst_issue_unit_pkg;

   localparam int WORD_SIZE    = 32;
   localparam int OPCODE_WIDTH = 6;
   localparam int FU_INDEX     = 3;
   localparam int FU_NUM       = 5;
   localparam int RB_INDEX     = 4;

   localparam logic [FU_INDEX-1:0] FU_IDLE = {FU_INDEX{1'b1}};
   localparam logic [RB_INDEX-1:0] NULL    = {RB_INDEX{1'b1}};

   localparam logic [OPCODE_WIDTH-1:0] INST_NOP = 6'h00;
   localparam logic [OPCODE_WIDTH-1:0] INST_ADD = 6'h01;
   localparam logic [OPCODE_WIDTH-1:0] INST_SUB = 6'h02;
   localparam logic [OPCODE_WIDTH-1:0] INST_AND = 6'h03;
   localparam logic [OPCODE_WIDTH-1:0] INST_OR  = 6'h04;
   localparam logic [OPCODE_WIDTH-1:0] INST_LW  = 6'h08;
   localparam logic [OPCODE_WIDTH-1:0] INST_SW  = 6'h09;
   localparam logic [OPCODE_WIDTH-1:0] INST_BGE = 6'h10;

   typedef enum logic [1:0] {
      CLASS_NONE = 2'd0,
      CLASS_ALU  = 2'd1,
      CLASS_MEM  = 2'd2,
      CLASS_BR   = 2'd3
   } fu_class_t;

   function automatic fu_class_t decode_class(input logic [OPCODE_WIDTH-1:0] op);
      fu_class_t c;
      case (op)
         INST_ADD, INST_SUB, INST_AND, INST_OR: c = CLASS_ALU;
         INST_LW, INST_SW:                      c = CLASS_MEM;
         INST_BGE:                              c = CLASS_BR;
         default:                               c = CLASS_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/inst_issue_unit_fu_select.sv
// Free-station picker for one FU class: lowest index wins, or round-robin from the
// last winner when ISSUE_ROUND_ROBIN_EN is defined.
module inst_issue_unit_fu_select
   import inst_issue_unit_pkg::*;
#(
   parameter int BASE = 0,
   parameter int CNT  = 1
) (
`ifdef ISSUE_ROUND_ROBIN_EN
   input  logic                clk,
   input  logic                reset_n,
   input  logic                advance,
`endif
   input  logic [CNT-1:0]      free,
   output logic                found,
   output logic [FU_INDEX-1:0] winner
);

`ifdef ISSUE_ROUND_ROBIN_EN
   localparam int PW = (CNT > 1) ? $clog2(CNT) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] win_off;

   // Scan offsets ptr+CNT down to ptr+1 so the nearest one after the pointer wins.
   always_comb begin
      found   = 1'b0;
      win_off = '0;
      for (int k = CNT; k >= 1; k--) begin
         if (free[(int'(ptr) + k) % CNT]) begin
            found   = 1'b1;
            win_off = PW'((int'(ptr) + k) % CNT);
         end
      end
   end

   assign winner = FU_INDEX'(BASE) + FU_INDEX'(win_off);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ptr <= PW'(CNT - 1);
      else if (advance && found)
         ptr <= win_off;
   end
`else
   always_comb begin
      found  = 1'b0;
      winner = FU_IDLE;
      for (int i = CNT - 1; i >= 0; i--) begin
         if (free[i]) begin
            found  = 1'b1;
            winner = FU_INDEX'(BASE + i);
         end
      end
   end
`endif

endmodule

// File: rtl/inst_issue_unit.sv
// In-order issue stage driving the CDB_inst broadcast to all reservation stations.
// Optional round-robin station selection per class: ISSUE_ROUND_ROBIN_EN.
module inst_issue_unit
   import inst_issue_unit_pkg::*;
#(
   parameter int ALU_BASE = 0,
   parameter int ALU_CNT  = 2,
   parameter int MEM_BASE = 2,
   parameter int MEM_CNT  = 2,
   parameter int BR_BASE  = 4,
   parameter int BR_CNT   = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] inst_in,
   input  logic                 inst_in_valid,
   output logic                 inst_in_ready,
   input  logic [FU_NUM-1:0]    busy_bus,
   input  logic                 rb_free,
   input  logic [RB_INDEX-1:0]  rb_tail,
   output logic                 rb_alloc,
   input  logic                 flush,
   output logic [FU_INDEX-1:0]  fu,
   output logic [RB_INDEX-1:0]  RB_index,
   output logic [WORD_SIZE-1:0] inst
);

   if (FU_NUM >= 2**FU_INDEX) begin : g_cfg_check
      $error("FU_NUM must be below 2**FU_INDEX so FU_IDLE never aliases a station");
   end

   logic                 held;
   logic [WORD_SIZE-1:0] held_inst;
   fu_class_t            cls;
   logic [FU_NUM-1:0]    reserved;
   logic [FU_NUM-1:0]    free;
   logic [1:0]           res_cnt [FU_NUM];
   logic                 alu_found, mem_found, br_found, sel_found, issue_now;
   logic [FU_INDEX-1:0]  alu_win, mem_win, br_win, sel_fu;

   assign cls = decode_class(held_inst[WORD_SIZE-1 -: OPCODE_WIDTH]);

   always_comb begin
      reserved = '0;
      for (int i = 0; i < FU_NUM; i++)
         reserved[i] = |res_cnt[i];
   end

   assign free = ~busy_bus & ~reserved;

   inst_issue_unit_fu_select #(.BASE(ALU_BASE), .CNT(ALU_CNT)) u_sel_alu (
`ifdef ISSUE_ROUND_ROBIN_EN
      .clk     (clk),
      .reset_n (reset_n),
      .advance (issue_now && (cls == CLASS_ALU)),
`endif
      .free    (free[ALU_BASE +: ALU_CNT]),
      .found   (alu_found),
      .winner  (alu_win)
   );

   inst_issue_unit_fu_select #(.BASE(MEM_BASE), .CNT(MEM_CNT)) u_sel_mem (
`ifdef ISSUE_ROUND_ROBIN_EN
      .clk     (clk),
      .reset_n (reset_n),
      .advance (issue_now && (cls == CLASS_MEM)),
`endif
      .free    (free[MEM_BASE +: MEM_CNT]),
      .found   (mem_found),
      .winner  (mem_win)
   );

   inst_issue_unit_fu_select #(.BASE(BR_BASE), .CNT(BR_CNT)) u_sel_br (
`ifdef ISSUE_ROUND_ROBIN_EN
      .clk     (clk),
      .reset_n (reset_n),
      .advance (issue_now && (cls == CLASS_BR)),
`endif
      .free    (free[BR_BASE +: BR_CNT]),
      .found   (br_found),
      .winner  (br_win)
   );

   always_comb begin
      sel_found = 1'b0;
      sel_fu    = FU_IDLE;
      case (cls)
         CLASS_ALU: begin sel_found = alu_found; sel_fu = alu_win; end
         CLASS_MEM: begin sel_found = mem_found; sel_fu = mem_win; end
         CLASS_BR:  begin sel_found = br_found;  sel_fu = br_win;  end
         default:   ;
      endcase
   end

   assign issue_now     = held && (cls != CLASS_NONE) && sel_found && rb_free && !flush;
   assign inst_in_ready = (!held || issue_now) && !flush;
   assign rb_alloc      = issue_now;

   // A NONE-class word is dropped one cycle after it is latched.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         held      <= 1'b0;
         held_inst <= '0;
      end else if (flush) begin
         held <= 1'b0;
      end else if (inst_in_valid && inst_in_ready) begin
         held      <= 1'b1;
         held_inst <= inst_in;
      end else if (held && (issue_now || (cls == CLASS_NONE))) begin
         held <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fu       <= FU_IDLE;
         RB_index <= NULL;
         inst     <= '0;
      end else if (issue_now) begin
         fu       <= sel_fu;
         RB_index <= rb_tail;
         inst     <= held_inst;
      end else begin
         fu       <= FU_IDLE;
         RB_index <= NULL;
         inst     <= '0;
      end
   end

   // Two-cycle hold-off covers the gap before the target station's busy_out rises.
   always_ff @(posedge clk or negedge reset_n) begin
      for (int i = 0; i < FU_NUM; i++) begin
         if (!reset_n)
            res_cnt[i] <= 2'd0;
         else if (issue_now && (sel_fu == FU_INDEX'(i)))
            res_cnt[i] <= 2'd2;
         else if (res_cnt[i] != 2'd0)
            res_cnt[i] <= res_cnt[i] - 2'd1;
      end
   end

endmodule

// File: tb/tb_inst_issue_unit.sv
// Scoreboard bench for inst_issue_unit: directed instructions push expected broadcasts,
// a negedge monitor pops and compares them. Follows ISSUE_ROUND_ROBIN_EN when defined.
module tb_inst_issue_unit;
   import inst_issue_unit_pkg::*;

`ifdef ISSUE_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic [WORD_SIZE-1:0] inst_in = '0;
   logic                 inst_in_valid = 1'b0;
   logic                 inst_in_ready;
   logic [FU_NUM-1:0]    busy_bus = '0;
   logic                 rb_free = 1'b1;
   logic [RB_INDEX-1:0]  rb_tail = '0;
   logic                 rb_alloc;
   logic                 flush = 1'b0;
   logic [FU_INDEX-1:0]  fu;
   logic [RB_INDEX-1:0]  RB_index;
   logic [WORD_SIZE-1:0] inst;

   inst_issue_unit dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .inst_in       (inst_in),
      .inst_in_valid (inst_in_valid),
      .inst_in_ready (inst_in_ready),
      .busy_bus      (busy_bus),
      .rb_free       (rb_free),
      .rb_tail       (rb_tail),
      .rb_alloc      (rb_alloc),
      .flush         (flush),
      .fu            (fu),
      .RB_index      (RB_index),
      .inst          (inst)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [FU_INDEX-1:0]  fu;
      logic [RB_INDEX-1:0]  rb;
      logic [WORD_SIZE-1:0] word;
      int                   at;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_alloc = 0;
   bit   prev_alloc = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_bcast(input int f, input int rb, input logic [WORD_SIZE-1:0] w, input int at);
      exp_t e;
      e.fu   = f[FU_INDEX-1:0];
      e.rb   = rb[RB_INDEX-1:0];
      e.word = w;
      e.at   = at;
      sb.push_back(e);
   endtask

   function automatic logic [WORD_SIZE-1:0] mk(input logic [OPCODE_WIDTH-1:0] op, input logic [25:0] rest);
      return {op, rest};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents w until accepted; acc is the cycle whose closing edge latched it.
   task automatic send(input logic [WORD_SIZE-1:0] w, output int acc);
      acc = -1;
      inst_in       = w;
      inst_in_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         #1;
         if (inst_in_ready) begin
            acc = cyc;
            tick();
            break;
         end
         tick();
      end
      inst_in_valid = 1'b0;
      if (acc < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: word %0h not accepted within 50 cycles, expected acceptance", w);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (fu !== FU_IDLE) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_bcast: fu=%0d inst=%0h at cycle %0d, expected idle", fu, inst, cyc);
            end else begin
               mon_e = sb.pop_front();
               check("bcast_fu", 32'(fu), 32'(mon_e.fu));
               check("bcast_rb", 32'(RB_index), 32'(mon_e.rb));
               check("bcast_inst", inst, mon_e.word);
               check("bcast_cycle", cyc, mon_e.at);
            end
         end
         if (prev_alloc || (fu !== FU_IDLE))
            check("alloc_then_bcast", {30'd0, prev_alloc, fu !== FU_IDLE}, 32'd3);
         if (rb_alloc) n_alloc++;
      end
      prev_alloc = reset_n && rb_alloc;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, c2, c3, r, f, a0;
      logic [WORD_SIZE-1:0] w, wa, wb, wc;
      int rr_exp [4];

      repeat (2) @(posedge clk);
      #1;
      check("rst_fu", 32'(fu), 32'(FU_IDLE));
      check("rst_rb", 32'(RB_index), 32'(NULL));
      check("rst_inst", inst, 32'd0);
      check("rst_alloc", 32'(rb_alloc), 32'd0);
      check("rst_ready", 32'(inst_in_ready), 32'd1);
      reset_n = 1'b1;
      tick();

      // single ALU op
      a0 = n_alloc;
      rb_tail = 4'd3;
      w = mk(INST_ADD, 26'h0012345);
      send(w, c);
      expect_bcast(0, 3, w, c + 2);
      repeat (4) tick();
      check("single_alloc_count", n_alloc - a0, 32'd1);

      // back-to-back ALU with stale busy_bus
      rb_tail = 4'd5;
      wa = mk(INST_ADD, 26'h0000a01);
      wb = mk(INST_SUB, 26'h0000b02);
      wc = mk(INST_AND, 26'h0000c03);
      send(wa, c);
      expect_bcast(RR ? 1 : 0, 5, wa, c + 2);
      send(wb, c2);
      check("b2b_accept_b", c2, c + 1);
      expect_bcast(RR ? 0 : 1, 5, wb, c2 + 2);
      send(wc, c3);
      check("b2b_accept_c", c3, c2 + 1);
      busy_bus = 5'b00011;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("b2b_stall_ready", 32'(inst_in_ready), 32'd0);
         tick();
      end
      busy_bus[0] = 1'b0;
      r = cyc;
      expect_bcast(0, 5, wc, r + 1);
      #1;
      check("b2b_release_alloc", 32'(rb_alloc), 32'd1);
      tick();
      busy_bus = '0;
      repeat (4) tick();

      // BGE while branch station busy
      a0 = n_alloc;
      busy_bus[4] = 1'b1;
      rb_tail = 4'd7;
      w = mk(INST_BGE, 26'h0abcdef);
      send(w, c);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bge_stall_ready", 32'(inst_in_ready), 32'd0);
         check("bge_stall_alloc", 32'(rb_alloc), 32'd0);
         tick();
      end
      busy_bus[4] = 1'b0;
      r = cyc;
      expect_bcast(4, 7, w, r + 1);
      repeat (5) tick();
      check("bge_alloc_count", n_alloc - a0, 32'd1);

      // rb_free low with free MEM station
      rb_free = 1'b0;
      rb_tail = 4'd9;
      w = mk(INST_LW, 26'h0001111);
      send(w, c);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("rob_stall_alloc", 32'(rb_alloc), 32'd0);
         check("rob_stall_ready", 32'(inst_in_ready), 32'd0);
         tick();
      end
      rb_free = 1'b1;
      r = cyc;
      expect_bcast(2, 9, w, r + 1);
      repeat (5) tick();

      // NOP consumed without broadcast, next op accepted two cycles later
      rb_tail = 4'd2;
      send(mk(INST_NOP, 26'h0000777), c);
      w = mk(INST_OR, 26'h0000888);
      send(w, c2);
      check("nop_consume", c2, c + 2);
      expect_bcast(RR ? 1 : 0, 2, w, c2 + 2);
      repeat (5) tick();

      // flush during stall, coinciding with the stall clearing
      a0 = n_alloc;
      busy_bus[4] = 1'b1;
      rb_tail = 4'd4;
      send(mk(INST_BGE, 26'h0000999), c);
      tick();
      f = cyc;
      flush = 1'b1;
      busy_bus[4] = 1'b0;
      #1;
      check("flush_ready", 32'(inst_in_ready), 32'd0);
      check("flush_alloc", 32'(rb_alloc), 32'd0);
      tick();
      flush = 1'b0;
      #1;
      check("flush_fu_idle", 32'(fu), 32'(FU_IDLE));
      check("flush_rb_null", 32'(RB_index), 32'(NULL));
      check("flush_inst_zero", inst, 32'd0);
      check("flush_ready_after", 32'(inst_in_ready), 32'd1);
      w = mk(INST_ADD, 26'h0000555);
      send(w, c3);
      check("flush_accept_next", c3, f + 1);
      expect_bcast(0, 4, w, c3 + 2);
      repeat (5) tick();
      check("flush_alloc_count", n_alloc - a0, 32'd1);

      // reset asserted in the broadcast cycle
      rb_tail = 4'd1;
      send(mk(INST_ADD, 26'h0000321), c);
      tick();
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_fu", 32'(fu), 32'(FU_IDLE));
      check("midrst_rb", 32'(RB_index), 32'(NULL));
      check("midrst_inst", inst, 32'd0);
      check("midrst_ready", 32'(inst_in_ready), 32'd1);
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      tick();
      tick();

      // four MEM ops with stations free each time
      if (RR) begin
         rr_exp[0] = 2; rr_exp[1] = 3; rr_exp[2] = 2; rr_exp[3] = 3;
      end else begin
         rr_exp[0] = 2; rr_exp[1] = 2; rr_exp[2] = 2; rr_exp[3] = 2;
      end
      rb_tail = 4'd6;
      for (int k = 0; k < 4; k++) begin
         w = mk(INST_SW, 26'(k + 16));
         send(w, c);
         expect_bcast(rr_exp[k], 6, w, c + 2);
         repeat (4) tick();
      end

      repeat (3) tick();
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
